fixed_timer: RTL and testbench
==============================

# fixed_timer

Free-running fixed-period timer that divides the system clock by a compile-time constant. It produces a square wave `out`, a one-cycle `tick` aligned with each rising edge of `out`, and the current phase count. Audio-path blocks such as the DAC sampler use it as their sample-rate source; the default period of 128 gives 32768 Hz from a 4.194304 MHz system clock.

## Interface
- `PERIOD`, default 128: length of one output period in enabled clock cycles; must be >= 2 (elaboration error otherwise).
- `CW`, derived (localparam): max(1, $clog2(PERIOD)), the counter width.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  count enable; when low, all state holds.
- `clr`  in  1  synchronous restart to phase 0; has priority over `en`.
- `out`  out  1  registered square wave, one period every PERIOD enabled cycles.
- `tick`  out  1  registered one-cycle pulse on the cycle `out` first goes high.
- `count`  out  CW  current phase, 0..PERIOD-1.

One clock; reset is asynchronous and active-low.

## Operation
- `LOW` = PERIOD − PERIOD/2 (integer division). The low phase is ceil(PERIOD/2) cycles and the high phase is floor(PERIOD/2) cycles.
- Phase counter `count`:
  - On each clk edge with `en`=1 and `clr`=0, `count` becomes 0 if it is at PERIOD−1; otherwise it increments by 1.
  - It never holds a value >= PERIOD.
- `out` is its own flop. Invariant: `out` == (`count` >= LOW) at all times, including after reset, clear, and hold. It must not be decoded combinationally at the port.
- `tick`:
  - Registered.
  - On an enabled, non-clear edge, `tick` takes the value (next `count` == LOW).
  - On any edge with `en`=0 or `clr`=1, `tick` takes 0.
  - As a result, `tick` is high for exactly one cycle per period, coincident with the rising edge of `out`.
- `clr`=1 on an edge forces `count`=0, `out`=0 and `tick`=0, regardless of `en`.
- `en`=0 with `clr`=0 holds `count` and `out`, and drives `tick` to 0.

## Timing
- Reset (`rst_n`=0), applied immediately and asynchronously: `count`=0, `out`=0, `tick`=0.
- Reset is released synchronously to clk. The first enabled edge after release gives `count`=1.
- Phase relationships from reset, with `en` held at 1:
  - `out` and `tick` rise after edge number LOW.
  - `out` falls after edge number PERIOD, when `count` wraps to 0.
  - Subsequent rises occur every PERIOD edges.
- Latency from the `en`/`clr` inputs to the outputs is one edge; there is no combinational path from input to output.
- Wrap-around: the edge taking `count` from PERIOD−1 to 0 drops `out` in the same cycle.
- Simultaneous `clr` and `en`: `clr` wins.
- `rst_n` asserted mid-period aborts the period immediately. No partial `tick` is emitted.
- PERIOD=2: `out` toggles every enabled edge and `tick` pulses every second edge.
- PERIOD odd: the low phase is one cycle longer than the high phase; for example, PERIOD=3 gives low 2, high 1.

## Structure
- Single module with no sub-modules.
- An optional shared timing package holds the system clock frequency constant and the default sample PERIOD (128). Consumers derive their periods from that package rather than hard-coding numbers.
- Internal next-count logic is a single combinational block feeding three flops (`count`, `out`, `tick`).

## Test plan
- Reset then free-run with PERIOD=128 and `en`=1: `out` rises after edge 64 with `tick`=1 for that one cycle. `out` falls after edge 128 with `count`=0. Next rise is after edge 192.
- PERIOD=3: the `out` sequence after reset over edges 1..6 is 0,1,0,0,1,0. `tick` is high exactly when `out` is 1.
- Hold with `en`=0 for 10 cycles at `count`=63: `count` stays 63 and `out` stays 0. On re-enable, the next edge gives `count`=64, `out`=1 and `tick`=1.
- `clr`=1 with `en`=1 at `count`=100: the next edge gives `count`=0, `out`=0 and `tick`=0. Counting then resumes from 1.
- Assert `rst_n`=0 asynchronously between edges while `out`=1: `out`, `tick` and `count` all go to 0 before the next clk edge.
- PERIOD=2: `out` alternates 1,0,1,0 from edge 1, and `tick` follows `out`.

Source files
------------

// File: rtl/fixed_timer_pkg.sv
// Shared timing constants for blocks derived from the system clock.
// Consumers take their periods from here instead of hard-coding numbers.
package fixed_timer_pkg;

  localparam int unsigned SYS_CLK_HZ    = 4194304;
  localparam int          SAMPLE_PERIOD = 128;

  // Counter width for a phase range of 0..p-1, never narrower than one bit.
  function automatic int cnt_width(input int p);
    return (p <= 2) ? 1 : $clog2(p);
  endfunction

endpackage

// File: rtl/fixed_timer.sv
// Free-running divide-by-PERIOD timer: square wave, rising-edge tick and phase count.
// All three outputs are flops fed by one next-state block, so nothing is decoded at the ports.
module fixed_timer
  import fixed_timer_pkg::*;
#(
  parameter  int PERIOD = SAMPLE_PERIOD,
  localparam int CW     = cnt_width(PERIOD)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  output logic          out,
  output logic          tick,
  output logic [CW-1:0] count
);

  if (PERIOD < 2) begin : g_bad_period
    $error("fixed_timer: PERIOD must be >= 2");
  end

  // Low phase takes the extra cycle when PERIOD is odd.
  localparam int          LOW    = PERIOD - PERIOD / 2;
  localparam logic [CW-1:0] LOW_C  = CW'(LOW);
  localparam logic [CW-1:0] LAST_C = CW'(PERIOD - 1);

  logic [CW-1:0] count_nxt;
  logic          out_nxt;
  logic          tick_nxt;

  always_comb begin
    count_nxt = count;
    out_nxt   = out;
    tick_nxt  = 1'b0;
    if (clr) begin
      count_nxt = '0;
      out_nxt   = 1'b0;
    end else if (en) begin
      count_nxt = (count == LAST_C) ? '0 : count + CW'(1);
      out_nxt   = (count_nxt >= LOW_C);
      tick_nxt  = (count_nxt == LOW_C);
    end
  end

  // ---- register stage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      out   <= 1'b0;
      tick  <= 1'b0;
    end else begin
      count <= count_nxt;
      out   <= out_nxt;
      tick  <= tick_nxt;
    end
  end

endmodule

// File: tb/tb_fixed_timer.sv
// Bench for fixed_timer at PERIOD 128, 3 and 2: vector table, corner sequences
// and random en/clr traffic against a phase-arithmetic reference model.
module tb_fixed_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic       out128, tick128;
  logic [6:0] cnt128;
  logic       out3, tick3;
  logic [1:0] cnt3;
  logic       out2, tick2;
  logic [0:0] cnt2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  fixed_timer #(.PERIOD(128)) u128 (.clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
                                    .out(out128), .tick(tick128), .count(cnt128));
  fixed_timer #(.PERIOD(3))   u3   (.clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
                                    .out(out3), .tick(tick3), .count(cnt3));
  fixed_timer #(.PERIOD(2))   u2   (.clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
                                    .out(out2), .tick(tick2), .count(cnt2));

  // Reference model: phase index and pending tick per instance.
  int per[3] = '{128, 3, 2};
  int ph[3];
  int mt[3];

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      ph[i] = 0;
      mt[i] = 0;
    end
  endfunction

  function automatic void model_step(input logic e, input logic c);
    for (int i = 0; i < 3; i++) begin
      if (c) begin
        ph[i] = 0;
        mt[i] = 0;
      end else if (e) begin
        ph[i] = (ph[i] + 1) % per[i];
        mt[i] = (ph[i] == per[i] - per[i] / 2) ? 1 : 0;
      end else begin
        mt[i] = 0;
      end
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int m_out(input int i);
    return (ph[i] >= per[i] - per[i] / 2) ? 1 : 0;
  endfunction

  task automatic chk_model(input string tag);
    chk({tag, " cnt128"},  int'(cnt128), ph[0]);
    chk({tag, " out128"},  int'(out128), m_out(0));
    chk({tag, " tick128"}, int'(tick128), mt[0]);
    chk({tag, " cnt3"},    int'(cnt3), ph[1]);
    chk({tag, " out3"},    int'(out3), m_out(1));
    chk({tag, " tick3"},   int'(tick3), mt[1]);
    chk({tag, " cnt2"},    int'(cnt2), ph[2]);
    chk({tag, " out2"},    int'(out2), m_out(2));
    chk({tag, " tick2"},   int'(tick2), mt[2]);
  endtask

  // One clock edge with the currently driven en/clr; returns #1 after the edge.
  task automatic step();
    model_step(en, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    en    = 1'b0;
    clr   = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic e;
    logic c;
    int   c3, o3, t3;
    int   c2, o2, t2;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1, 0, 0, 1, 1, 1};
    tbl[1]  = '{1'b1, 1'b0, 2, 1, 1, 0, 0, 0};
    tbl[2]  = '{1'b1, 1'b0, 0, 0, 0, 1, 1, 1};
    tbl[3]  = '{1'b1, 1'b0, 1, 0, 0, 0, 0, 0};
    tbl[4]  = '{1'b1, 1'b0, 2, 1, 1, 1, 1, 1};
    tbl[5]  = '{1'b1, 1'b0, 0, 0, 0, 0, 0, 0};
    tbl[6]  = '{1'b0, 1'b0, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{1'b1, 1'b0, 1, 0, 0, 1, 1, 1};
    tbl[8]  = '{1'b0, 1'b0, 1, 0, 0, 1, 1, 0};
    tbl[9]  = '{1'b1, 1'b1, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{1'b1, 1'b0, 1, 0, 0, 1, 1, 1};

    rst_n = 1'b0;
    en    = 1'b0;
    clr   = 1'b0;
    model_reset();
    #2;
    chk("reset cnt128", int'(cnt128), 0);
    chk("reset out128", int'(out128), 0);
    chk("reset tick128", int'(tick128), 0);
    do_reset();

    // Short-period vectors from reset.
    for (int i = 0; i < 11; i++) begin
      en  = tbl[i].e;
      clr = tbl[i].c;
      step();
      chk($sformatf("vec%0d cnt3", i),  int'(cnt3),  tbl[i].c3);
      chk($sformatf("vec%0d out3", i),  int'(out3),  tbl[i].o3);
      chk($sformatf("vec%0d tick3", i), int'(tick3), tbl[i].t3);
      chk($sformatf("vec%0d cnt2", i),  int'(cnt2),  tbl[i].c2);
      chk($sformatf("vec%0d out2", i),  int'(out2),  tbl[i].o2);
      chk($sformatf("vec%0d tick2", i), int'(tick2), tbl[i].t2);
    end

    // Free run at PERIOD 128.
    do_reset();
    en = 1'b1;
    steps(63);
    chk("run63 out", int'(out128), 0);
    step();
    chk("rise64 cnt", int'(cnt128), 64);
    chk("rise64 out", int'(out128), 1);
    chk("rise64 tick", int'(tick128), 1);
    step();
    chk("edge65 tick", int'(tick128), 0);
    chk("edge65 out", int'(out128), 1);
    steps(63);
    chk("wrap128 cnt", int'(cnt128), 0);
    chk("wrap128 out", int'(out128), 0);
    steps(64);
    chk("rise192 out", int'(out128), 1);
    chk("rise192 tick", int'(tick128), 1);

    // Hold at count 63, then re-enable.
    do_reset();
    en = 1'b1;
    steps(63);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("hold cnt", int'(cnt128), 63);
      chk("hold out", int'(out128), 0);
      chk("hold tick", int'(tick128), 0);
    end
    en = 1'b1;
    step();
    chk("reen cnt", int'(cnt128), 64);
    chk("reen out", int'(out128), 1);
    chk("reen tick", int'(tick128), 1);

    // Clear with enable at count 100.
    do_reset();
    en = 1'b1;
    steps(100);
    chk("pre-clr cnt", int'(cnt128), 100);
    clr = 1'b1;
    step();
    chk("clr cnt", int'(cnt128), 0);
    chk("clr out", int'(out128), 0);
    chk("clr tick", int'(tick128), 0);
    clr = 1'b0;
    step();
    chk("post-clr cnt", int'(cnt128), 1);

    // Asynchronous reset mid-period while out is high.
    do_reset();
    en = 1'b1;
    steps(70);
    chk("pre-arst out", int'(out128), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst cnt", int'(cnt128), 0);
    chk("arst out", int'(out128), 0);
    chk("arst tick", int'(tick128), 0);
    chk("arst cnt3", int'(cnt3), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    chk("post-arst cnt", int'(cnt128), 1);
    chk("post-arst out", int'(out128), 0);

    // Random en/clr traffic against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      en  = ($urandom % 4) != 0;
      clr = ($urandom % 32) == 0;
      step();
      chk_model("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
